bus_decoder: RTL and testbench

//  Parametrised single-master peripheral bus decoder, replacing the fixed 4-slave bus.

---
 rtl/bus_decoder.sv | 187 ++++++++++++++++++
 tb/tb_bus_decoder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_decoder.sv
// Single-master peripheral bus decoder: routes one access to a slave picked
// by m_addr_i[IDX_LSB+:4], with per-access timeout and unmapped-address errors.
// Ports: clk/rst; master m_addr_i/m_data_i/m_sel_i/m_rd_i/m_we_i -> m_data_o/m_ack_o;
// slaves s_addr_o/s_data_o/s_sel_o/s_rd_o/s_we_o <- s_data_i/s_ack_i;
// bus_err_o interrupt pulse and sticky err_addr_o.
module bus_decoder #(
    parameter int          NUM_SLAVES = 4,
    parameter int          IDX_LSB    = 20,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                m_addr_i,
    input  logic [31:0]                m_data_i,
    output logic [31:0]                m_data_o,
    input  logic [1:0]                 m_sel_i,
    input  logic                       m_rd_i,
    input  logic                       m_we_i,
    output logic                       m_ack_o,
    output logic [31:0]                s_addr_o,
    output logic [31:0]                s_data_o,
    output logic [1:0]                 s_sel_o,
    output logic [NUM_SLAVES-1:0]      s_rd_o,
    output logic [NUM_SLAVES-1:0]      s_we_o,
    input  logic [32*NUM_SLAVES-1:0]   s_data_i,
    input  logic [NUM_SLAVES-1:0]      s_ack_i,
    output logic                       bus_err_o,
    output logic [31:0]                err_addr_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Timeout fires on the edge where the counter would reach TIMEOUT.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic [31:0]           s_addr_q, s_addr_d;
    logic [31:0]           s_data_q, s_data_d;
    logic [1:0]            s_sel_q, s_sel_d;
    logic [NUM_SLAVES-1:0] s_rd_q, s_rd_d;
    logic [NUM_SLAVES-1:0] s_we_q, s_we_d;
    logic [3:0]            idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  m_ack_q, m_ack_d;
    logic [31:0]           m_data_q, m_data_d;
    logic                  bus_err_q, bus_err_d;
    logic [31:0]           err_addr_q, err_addr_d;

    logic [3:0]            req_idx;
    logic [NUM_SLAVES-1:0] req_hot;
    logic                  sel_ack;
    logic [31:0]           sel_data;

    assign req_idx = m_addr_i[IDX_LSB +: 4];

    // Compare against each slave number rather than indexing with the raw
    // 4-bit field, so indices beyond NUM_SLAVES simply decode to nothing.
    always_comb begin
        req_hot  = '0;
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            req_hot[k] = (req_idx == 4'(k));
            if (idx_q == 4'(k)) begin
                sel_ack  = s_ack_i[k];
                sel_data = s_data_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        s_addr_d   = s_addr_q;
        s_data_d   = s_data_q;
        s_sel_d    = s_sel_q;
        s_rd_d     = s_rd_q;
        s_we_d     = s_we_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        m_ack_d    = 1'b0;
        m_data_d   = m_data_q;
        bus_err_d  = 1'b0;
        err_addr_d = err_addr_q;

        case (state_q)
            S_IDLE: begin
                if (m_rd_i || m_we_i) begin
                    s_addr_d = m_addr_i;
                    s_data_d = m_data_i;
                    s_sel_d  = m_sel_i;
                    idx_d    = req_idx;
                    wr_d     = m_we_i;
                    if (|req_hot) begin
                        // Write wins when both strobes are high.
                        s_we_d  = m_we_i ? req_hot : '0;
                        s_rd_d  = m_we_i ? '0 : req_hot;
                        cnt_d   = '0;
                        state_d = S_ACCESS;
                    end else begin
                        m_ack_d    = 1'b1;
                        m_data_d   = ERR_DATA;
                        bus_err_d  = 1'b1;
                        err_addr_d = m_addr_i;
                        state_d    = S_DONE;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
                // Ack is checked first so it beats a same-cycle timeout.
                if (sel_ack) begin
                    s_rd_d  = '0;
                    s_we_d  = '0;
                    m_ack_d = 1'b1;
                    if (!wr_q) begin
                        m_data_d = sel_data;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    s_rd_d     = '0;
                    s_we_d     = '0;
                    m_ack_d    = 1'b1;
                    m_data_d   = ERR_DATA;
                    bus_err_d  = 1'b1;
                    err_addr_d = s_addr_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (!m_rd_i && !m_we_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            s_addr_q   <= '0;
            s_data_q   <= '0;
            s_sel_q    <= '0;
            s_rd_q     <= '0;
            s_we_q     <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            m_ack_q    <= 1'b0;
            m_data_q   <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            s_addr_q   <= s_addr_d;
            s_data_q   <= s_data_d;
            s_sel_q    <= s_sel_d;
            s_rd_q     <= s_rd_d;
            s_we_q     <= s_we_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            m_ack_q    <= m_ack_d;
            m_data_q   <= m_data_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign m_data_o   = m_data_q;
    assign m_ack_o    = m_ack_q;
    assign s_addr_o   = s_addr_q;
    assign s_data_o   = s_data_q;
    assign s_sel_o    = s_sel_q;
    assign s_rd_o     = s_rd_q;
    assign s_we_o     = s_we_q;
    assign bus_err_o  = bus_err_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder (4 slaves, TIMEOUT=8).
// Expected completions are queued at issue and popped on m_ack_o.
module tb_bus_decoder;

    localparam int          NS  = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       m_addr_i, m_data_i, m_data_o;
    logic [1:0]        m_sel_i;
    logic              m_rd_i, m_we_i, m_ack_o;
    logic [31:0]       s_addr_o, s_data_o;
    logic [1:0]        s_sel_o;
    logic [NS-1:0]     s_rd_o, s_we_o;
    logic [32*NS-1:0]  s_data_i;
    logic [NS-1:0]     s_ack_i;
    logic              bus_err_o;
    logic [31:0]       err_addr_o;

    always #5 clk = ~clk;

    bus_decoder #(
        .NUM_SLAVES(NS),
        .IDX_LSB   (20),
        .TIMEOUT   (TO),
        .ERR_DATA  (ERR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_addr_i  (m_addr_i),
        .m_data_i  (m_data_i),
        .m_data_o  (m_data_o),
        .m_sel_i   (m_sel_i),
        .m_rd_i    (m_rd_i),
        .m_we_i    (m_we_i),
        .m_ack_o   (m_ack_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_sel_o   (s_sel_o),
        .s_rd_o    (s_rd_o),
        .s_we_o    (s_we_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i),
        .bus_err_o (bus_err_o),
        .err_addr_o(err_addr_o)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] eaddr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   fails  = 0;
    int   lat;

    // Advance negedge by negedge until m_ack_o; lat = -1 if never seen.
    task automatic wait_ack(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (m_ack_o === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic rd, input logic we);
        m_addr_i = a;
        m_data_i = d;
        m_sel_i  = s;
        m_rd_i   = rd;
        m_we_i   = we;
    endtask

    task automatic release_master();
        m_rd_i = 1'b0;
        m_we_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Pops the queued expectation and compares the completion outputs.
    task automatic test_pop(input string nm);
        checks++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s scoreboard empty at ack", nm);
        end else begin
            e = sb.pop_front();
            if ({m_data_o, bus_err_o, err_addr_o} !== {e.data, e.err, e.eaddr}) begin
                fails++;
                $display("FAIL %s completion data=%h err=%b eaddr=%h expected data=%h err=%b eaddr=%h",
                         nm, m_data_o, bus_err_o, err_addr_o, e.data, e.err, e.eaddr);
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        s_ack_i  = '0;
        s_data_i = '0;
        issue(32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({m_ack_o, bus_err_o, s_rd_o, s_we_o} !== '0) begin
            fails++;
            $display("FAIL reset_strobes got ack=%b err=%b rd=%b we=%b expected all 0",
                     m_ack_o, bus_err_o, s_rd_o, s_we_o);
        end
        checks++;
        if ({m_data_o, err_addr_o, s_addr_o, s_data_o, s_sel_o} !== '0) begin
            fails++;
            $display("FAIL reset_regs got data=%h eaddr=%h saddr=%h sdata=%h sel=%h expected 0",
                     m_data_o, err_addr_o, s_addr_o, s_data_o, s_sel_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        issue(32'h0010_0040, 32'h0, 2'd2, 1'b1, 1'b0);
        sb.push_back('{data: 32'h12345678, err: 1'b0, eaddr: 32'h0});
        @(negedge clk);
        checks++;
        if (s_rd_o !== 4'b0010 || s_we_o !== 4'b0000) begin
            fails++;
            $display("FAIL read_strobe got rd=%b we=%b expected rd=0010 we=0000", s_rd_o, s_we_o);
        end
        checks++;
        if (s_addr_o !== 32'h0010_0040) begin
            fails++;
            $display("FAIL read_saddr got %h expected 00100040", s_addr_o);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (s_rd_o !== 4'b0010 || m_ack_o !== 1'b0) begin
            fails++;
            $display("FAIL read_hold got rd=%b ack=%b expected rd=0010 ack=0", s_rd_o, m_ack_o);
        end
        s_data_i[32*1 +: 32] = 32'h12345678;
        s_ack_i = 4'b0010;
        wait_ack(10, lat);
        s_ack_i = '0;
        checks++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL read_latency got %0d expected 1", lat);
        end
        test_pop("read");
        checks++;
        if (s_rd_o !== 4'b0000) begin
            fails++;
            $display("FAIL read_drop got rd=%b expected 0000", s_rd_o);
        end
        @(negedge clk);
        checks++;
        if (m_ack_o !== 1'b0 || m_data_o !== 32'h12345678) begin
            fails++;
            $display("FAIL read_pulse got ack=%b data=%h expected ack=0 data=12345678",
                     m_ack_o, m_data_o);
        end
        release_master();
    endtask

    task automatic test_write();
        issue(32'h0020_0100, 32'hCAFEF00D, 2'd0, 1'b0, 1'b1);
        sb.push_back('{data: 32'h12345678, err: 1'b0, eaddr: 32'h0});
        @(negedge clk);
        checks++;
        if (s_we_o !== 4'b0100 || s_rd_o !== 4'b0000) begin
            fails++;
            $display("FAIL write_strobe got we=%b rd=%b expected we=0100 rd=0000", s_we_o, s_rd_o);
        end
        checks++;
        if (s_data_o !== 32'hCAFEF00D || s_sel_o !== 2'd0) begin
            fails++;
            $display("FAIL write_payload got data=%h sel=%0d expected cafef00d sel=0",
                     s_data_o, s_sel_o);
        end
        s_ack_i = 4'b0100;
        wait_ack(10, lat);
        s_ack_i = '0;
        checks++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL write_latency got %0d expected 1", lat);
        end
        test_pop("write");
        release_master();
    endtask

    task automatic test_unmapped();
        issue(32'h0070_0004, 32'h0, 2'd2, 1'b1, 1'b0);
        sb.push_back('{data: ERR, err: 1'b1, eaddr: 32'h0070_0004});
        wait_ack(10, lat);
        checks++;
        if (lat !== 1 || s_rd_o !== 4'b0000 || s_we_o !== 4'b0000) begin
            fails++;
            $display("FAIL unmapped_ack got lat=%0d rd=%b we=%b expected lat=1 no strobes",
                     lat, s_rd_o, s_we_o);
        end
        test_pop("unmapped");
        @(negedge clk);
        checks++;
        if (m_ack_o !== 1'b0 || bus_err_o !== 1'b0) begin
            fails++;
            $display("FAIL unmapped_pulse got ack=%b err=%b expected 0 0", m_ack_o, bus_err_o);
        end
        release_master();
    endtask

    task automatic test_timeout();
        int extra;
        issue(32'h0000_0010, 32'h0, 2'd2, 1'b1, 1'b0);
        sb.push_back('{data: ERR, err: 1'b1, eaddr: 32'h0000_0010});
        @(negedge clk);
        checks++;
        if (s_rd_o !== 4'b0001) begin
            fails++;
            $display("FAIL timeout_strobe got rd=%b expected 0001", s_rd_o);
        end
        wait_ack(20, lat);
        checks++;
        if (lat !== TO || s_rd_o !== 4'b0000) begin
            fails++;
            $display("FAIL timeout_latency got lat=%0d rd=%b expected lat=%0d rd=0000",
                     lat, s_rd_o, TO);
        end
        test_pop("timeout");
        m_rd_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        s_data_i[31:0] = 32'h5555AAAA;
        s_ack_i = 4'b0001;
        @(negedge clk);
        s_ack_i = '0;
        extra = (m_ack_o === 1'b1) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m_ack_o === 1'b1 || s_rd_o !== '0) extra++;
        end
        checks++;
        if (extra != 0 || m_data_o !== ERR) begin
            fails++;
            $display("FAIL timeout_late_ack got extra=%0d data=%h expected 0 %h",
                     extra, m_data_o, ERR);
        end
    endtask

    task automatic test_rdwr_race();
        issue(32'h0030_0008, 32'h0BADF00D, 2'd1, 1'b1, 1'b1);
        sb.push_back('{data: ERR, err: 1'b0, eaddr: 32'h0000_0010});
        @(negedge clk);
        checks++;
        if (s_we_o !== 4'b1000 || s_rd_o !== 4'b0000) begin
            fails++;
            $display("FAIL rdwr_strobe got we=%b rd=%b expected we=1000 rd=0000", s_we_o, s_rd_o);
        end
        repeat (TO - 1) @(negedge clk);
        s_ack_i = 4'b1000;
        wait_ack(10, lat);
        s_ack_i = '0;
        checks++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL rdwr_latency got %0d expected 1", lat);
        end
        test_pop("rdwr_ack_vs_timeout");
        release_master();
    endtask

    task automatic test_reset_mid_access();
        issue(32'h0010_0000, 32'h0, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_rd_o !== '0 || s_we_o !== '0 || m_ack_o !== 1'b0 || err_addr_o !== '0) begin
            fails++;
            $display("FAIL rst_mid got rd=%b we=%b ack=%b eaddr=%h expected all 0",
                     s_rd_o, s_we_o, m_ack_o, err_addr_o);
        end
        rst    = 1'b0;
        m_rd_i = 1'b0;
        @(negedge clk);
        issue(32'h0000_0020, 32'h0, 2'd2, 1'b1, 1'b0);
        sb.push_back('{data: 32'h600DF00D, err: 1'b0, eaddr: 32'h0});
        @(negedge clk);
        s_data_i[31:0] = 32'h600DF00D;
        s_ack_i = 4'b0001;
        wait_ack(10, lat);
        s_ack_i = '0;
        checks++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL rst_after_latency got %0d expected 1", lat);
        end
        test_pop("rst_after");
        release_master();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_rdwr_race();
        test_reset_mid_access();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
